// File: rtl/i2s_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_capture_ctrl
//  Brief    : I2S master clock generator, start/stop sequencer and stereo
//             pair packer feeding a FRAME_LEN-block AXI-Stream output.
//  Revision : 1.0  initial release
// ============================================================================
module i2s_capture_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int SCK_DIV       = 16,
   parameter int BITS_PER_SLOT = 32,
   parameter int FRAME_LEN     = 1024
) (
   input  logic                    M_AXIS_ACLK,
   input  logic                    M_AXIS_ARESET,
   input  logic                    enable,
   input  logic                    clear_overflow,
   output logic                    sck,
   output logic                    ws,
   input  logic                    S_AXIS_TVALID,
   input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic                    S_AXIS_TLAST,
   output logic                    S_AXIS_TREADY,
   output logic                    M_AXIS_TVALID,
   input  logic                    M_AXIS_TREADY,
   output logic [2*DATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic                    M_AXIS_TLAST,
   output logic                    busy,
   output logic                    overflow
);

   localparam int c_DIV_W = (SCK_DIV > 1)       ? $clog2(SCK_DIV)       : 1;
   localparam int c_BIT_W = (BITS_PER_SLOT > 1) ? $clog2(BITS_PER_SLOT) : 1;
   localparam int c_BLK_W = (FRAME_LEN > 1)     ? $clog2(FRAME_LEN)     : 1;

   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCK_DIV - 1);
   localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(BITS_PER_SLOT - 1);
   localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2,
      ST_STOP = 2'd3
   } state_t;

   state_t                  r_state;
   logic                    r_busy;
   logic [c_DIV_W-1:0]      r_div;
   logic [c_BIT_W-1:0]      r_bit;
   logic                    r_sck;
   logic                    r_ws;
   logic [DATA_WIDTH-1:0]   r_hold;
   logic                    r_left_ok;
   logic [c_BLK_W-1:0]      r_blk;
   logic                    r_tvalid;
   logic [2*DATA_WIDTH-1:0] r_tdata;
   logic                    r_tlast;
   logic                    r_overflow;

   logic w_active;
   logic w_div_wrap;
   logic w_slot_end;
   logic w_hs;
   logic w_pairing;
   logic w_left;
   logic w_right;
   logic w_can_load;
   logic w_stop_done;

   assign w_active    = (r_state != ST_IDLE);
   assign w_div_wrap  = (r_div == c_DIV_LAST);
   assign w_slot_end  = (r_bit == c_BIT_LAST);
   assign w_hs        = r_tvalid & M_AXIS_TREADY;
   assign w_pairing   = (r_state == ST_RUN) | (r_state == ST_STOP);
   assign w_left      = w_pairing & S_AXIS_TVALID & ~S_AXIS_TLAST;
   assign w_right     = w_pairing & S_AXIS_TVALID & S_AXIS_TLAST & r_left_ok;
   assign w_can_load  = ~r_tvalid | w_hs;
   assign w_stop_done = (r_state == ST_STOP) & w_hs & r_tlast;

   // Sequencer: SYNC discards words up to the first right-channel word so
   // that pairing always starts on a complete frame boundary.
   always_ff @(posedge M_AXIS_ACLK) begin
      if (M_AXIS_ARESET) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable) begin
                  r_state <= ST_SYNC;
                  r_busy  <= 1'b1;
               end
            end
            ST_SYNC: begin
               if (S_AXIS_TVALID && S_AXIS_TLAST) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_stop_done) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Bit clock and word select; bit/slot counting advances on sck falls.
   always_ff @(posedge M_AXIS_ACLK) begin
      if (M_AXIS_ARESET || !w_active || w_stop_done) begin
         r_div <= '0;
         r_bit <= '0;
         r_sck <= 1'b0;
         r_ws  <= 1'b0;
      end else if (w_div_wrap) begin
         r_div <= '0;
         r_sck <= ~r_sck;
         if (r_sck) begin
            if (w_slot_end) begin
               r_bit <= '0;
               r_ws  <= ~r_ws;
            end else begin
               r_bit <= r_bit + 1'b1;
            end
         end
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // Pair packer and output register. A pair that cannot be loaded because
   // the output is stalled is dropped and flagged rather than queued.
   always_ff @(posedge M_AXIS_ACLK) begin
      if (M_AXIS_ARESET) begin
         r_hold     <= '0;
         r_left_ok  <= 1'b0;
         r_blk      <= '0;
         r_tvalid   <= 1'b0;
         r_tdata    <= '0;
         r_tlast    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (clear_overflow) begin
            r_overflow <= 1'b0;
         end
         if (w_hs) begin
            r_tvalid <= 1'b0;
         end
         if (w_stop_done) begin
            r_blk     <= '0;
            r_left_ok <= 1'b0;
         end else if (w_left) begin
            r_hold    <= S_AXIS_TDATA;
            r_left_ok <= 1'b1;
         end else if (w_right) begin
            r_left_ok <= 1'b0;
            if (w_can_load) begin
               r_tdata  <= {r_hold, S_AXIS_TDATA};
               r_tvalid <= 1'b1;
               r_tlast  <= (r_blk == c_BLK_LAST);
               if (r_blk == c_BLK_LAST) begin
                  r_blk <= '0;
               end else begin
                  r_blk <= r_blk + 1'b1;
               end
            end else begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   assign sck           = r_sck;
   assign ws            = r_ws;
   assign S_AXIS_TREADY = 1'b1;
   assign M_AXIS_TVALID = r_tvalid;
   assign M_AXIS_TDATA  = r_tdata;
   assign M_AXIS_TLAST  = r_tlast;
   assign busy          = r_busy;
   assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_i2s_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_capture_ctrl
//  Brief    : Directed self-checking bench for i2s_capture_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2s_capture_ctrl;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          clear_overflow;
   logic          sck;
   logic          ws;
   logic          s_tvalid;
   logic [DW-1:0] s_tdata;
   logic          s_tlast;
   logic          s_tready;
   logic          m_tvalid;
   logic          m_tready;
   logic [2*DW-1:0] m_tdata;
   logic          m_tlast;
   logic          busy;
   logic          overflow;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   i2s_capture_ctrl #(
      .DATA_WIDTH   (DW),
      .SCK_DIV      (16),
      .BITS_PER_SLOT(32),
      .FRAME_LEN    (4)
   ) u_dut (
      .M_AXIS_ACLK   (clk),
      .M_AXIS_ARESET (rst),
      .enable        (enable),
      .clear_overflow(clear_overflow),
      .sck           (sck),
      .ws            (ws),
      .S_AXIS_TVALID (s_tvalid),
      .S_AXIS_TDATA  (s_tdata),
      .S_AXIS_TLAST  (s_tlast),
      .S_AXIS_TREADY (s_tready),
      .M_AXIS_TVALID (m_tvalid),
      .M_AXIS_TREADY (m_tready),
      .M_AXIS_TDATA  (m_tdata),
      .M_AXIS_TLAST  (m_tlast),
      .busy          (busy),
      .overflow      (overflow)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [DW-1:0] d, input logic last);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = last;
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
   endtask

   task automatic start_capture();
      rst    = 1'b1;
      enable = 1'b0;
      tick();
      tick();
      rst    = 1'b0;
      enable = 1'b1;
      tick();
      send_word(32'hDEAD, 1'b1);
   endtask

   initial begin
      int n;
      logic [8:0] t3_last;
      t3_last = 9'b010001000;

      rst = 1'b1; enable = 1'b0; clear_overflow = 1'b0;
      s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;

      // T1: reset state, start-up and clock generation
      tick();
      tick();
      check("rst_sck", sck, 0);
      check("rst_ws", ws, 0);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_tlast", m_tlast, 0);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      check("s_tready", s_tready, 1);

      rst = 1'b0; enable = 1'b1;
      tick();
      check("busy_start", busy, 1);
      n = 0;
      while (sck == 1'b0 && n < 100) begin tick(); n++; end
      check("sck_first_rise", n, 16);
      n = 0;
      while (sck == 1'b1 && n < 100) begin tick(); n++; end
      check("sck_high_len", n, 16);
      n = 0;
      while (sck == 1'b0 && n < 100) begin tick(); n++; end
      check("sck_low_len", n, 16);
      n = 0;
      while (ws == 1'b0 && n < 3000) begin tick(); n++; end
      check("ws_first_toggle", n, 976);
      check("ws_on_sck_fall", sck, 0);
      n = 0;
      while (ws == 1'b1 && n < 3000) begin tick(); n++; end
      check("ws_period", n, 1024);

      // T2: partial first frame discarded
      send_word(32'h11, 1'b0);
      send_word(32'h22, 1'b1);
      check("sync_drop", m_tvalid, 0);
      send_word(32'hA, 1'b0);
      check("sync_no_early", m_tvalid, 0);
      send_word(32'hB, 1'b1);
      check("first_valid", m_tvalid, 1);
      check("first_data", m_tdata, 64'h0000000A_0000000B);
      check("first_last", m_tlast, 0);
      tick();
      check("first_cleared", m_tvalid, 0);

      // T3: TLAST every FRAME_LEN pairs
      start_capture();
      for (int p = 1; p <= 9; p++) begin
         send_word(DW'(p), 1'b0);
         send_word(DW'(p + 100), 1'b1);
         check("blk_valid", m_tvalid, 1);
         check("blk_data", m_tdata, {DW'(p), DW'(p + 100)});
         check("blk_last", m_tlast, t3_last[p-1]);
      end
      tick();

      // T4: backpressure, drop and overflow clear
      m_tready = 1'b0;
      send_word(32'hA1, 1'b0);
      send_word(32'hB1, 1'b1);
      check("bp_valid", m_tvalid, 1);
      send_word(32'hA2, 1'b0);
      send_word(32'hB2, 1'b1);
      tick();
      check("bp_hold_valid", m_tvalid, 1);
      check("bp_hold_data", m_tdata, 64'h000000A1_000000B1);
      check("bp_overflow", overflow, 1);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      check("ovf_cleared", overflow, 0);
      m_tready = 1'b1;
      tick();
      check("bp_drain", m_tvalid, 0);

      // T5: stop request mid-block completes the block
      start_capture();
      send_word(32'h1, 1'b0);
      send_word(32'h2, 1'b1);
      send_word(32'h3, 1'b0);
      send_word(32'h4, 1'b1);
      enable = 1'b0;
      tick();
      send_word(32'h5, 1'b0);
      send_word(32'h6, 1'b1);
      check("stop_p3_data", m_tdata, 64'h00000005_00000006);
      check("stop_p3_last", m_tlast, 0);
      send_word(32'h7, 1'b0);
      check("stop_busy", busy, 1);
      send_word(32'h8, 1'b1);
      check("stop_p4_valid", m_tvalid, 1);
      check("stop_p4_data", m_tdata, 64'h00000007_00000008);
      check("stop_p4_last", m_tlast, 1);
      tick();
      check("stop_idle_busy", busy, 0);
      check("stop_idle_sck", sck, 0);
      check("stop_idle_ws", ws, 0);
      check("stop_idle_tvalid", m_tvalid, 0);

      // T6: reset in the middle of an active transfer
      start_capture();
      m_tready = 1'b0;
      send_word(32'hC1, 1'b0);
      send_word(32'hD1, 1'b1);
      send_word(32'hC2, 1'b0);
      send_word(32'hD2, 1'b1);
      n = 0;
      while (sck == 1'b0 && n < 40) begin tick(); n++; end
      check("t6_pre_sck", sck, 1);
      check("t6_pre_valid", m_tvalid, 1);
      check("t6_pre_ovf", overflow, 1);
      rst = 1'b1;
      tick();
      check("t6_tvalid", m_tvalid, 0);
      check("t6_busy", busy, 0);
      check("t6_overflow", overflow, 0);
      check("t6_sck", sck, 0);
      check("t6_tdata", m_tdata, 0);
      rst = 1'b0;
      m_tready = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
